// File: rtl/control_sequencer_if.sv
// Instruction/flag inputs and control-strobe outputs of the microcoded sequencer.
interface control_sequencer_if #(
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned CTRL_W  = 16
);
    logic [INSTR_W-1:0] INSTR_IN;
    logic               CARRY_IN;
    logic               ZERO_IN;
    logic [CTRL_W-1:0]  CTRL_WORD;
    logic [2:0]         STEP_OUT;

    modport master (
        output INSTR_IN, CARRY_IN, ZERO_IN,
        input  CTRL_WORD, STEP_OUT
    );

    modport slave (
        input  INSTR_IN, CARRY_IN, ZERO_IN,
        output CTRL_WORD, STEP_OUT
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded fetch/execute sequencer: steps T0-T4, latches the opcode at the end
// of T1 and decodes the datapath strobe word from step, opcode and flags.
module control_sequencer #(
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned CTRL_W  = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    control_sequencer_if.slave  bus
);
    localparam int unsigned OP_W = 4;

    localparam int unsigned PC_INC     = 0;
    localparam int unsigned PC_OUT     = 1;
    localparam int unsigned JUMP       = 2;
    localparam int unsigned MAR_LOAD   = 3;
    localparam int unsigned RAM_OUT    = 4;
    localparam int unsigned RAM_IN     = 5;
    localparam int unsigned IR_LOAD    = 6;
    localparam int unsigned IR_OUT     = 7;
    localparam int unsigned A_LOAD     = 8;
    localparam int unsigned A_OUT      = 9;
    localparam int unsigned B_LOAD     = 10;
    localparam int unsigned ALU_OUT    = 11;
    localparam int unsigned ALU_SUB    = 12;
    localparam int unsigned FLAGS_LOAD = 13;
    localparam int unsigned OUT_LOAD   = 14;
    localparam int unsigned HALT       = 15;

    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JC  = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0     = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        T4     = 3'd4,
        S_RST  = 3'd5,
        S_HALT = 3'd6
    } step_t;

    step_t             step;
    logic [OP_W-1:0]   opcode;
    logic [CTRL_W-1:0] ctrl;

    // Step/opcode register; unused encoding 7 falls back to S_RST.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            step   <= S_RST;
            opcode <= '0;
        end else begin
            case (step)
                S_RST: step <= T0;
                T0:    step <= T1;
                T1: begin
                    step   <= T2;
                    opcode <= bus.INSTR_IN[INSTR_W-1 -: OP_W];
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: step <= T3;
                        OP_HLT:                         step <= S_HALT;
                        default:                        step <= T0;
                    endcase
                end
                T3:      step <= (opcode == OP_ADD || opcode == OP_SUB) ? T4 : T0;
                T4:      step <= T0;
                S_HALT:  step <= S_HALT;
                default: step <= S_RST;
            endcase
        end
    end

    // Strobe decode; only one bus driver is ever enabled per step.
    always_comb begin
        ctrl = '0;
        case (step)
            T0: begin
                ctrl[PC_OUT]   = 1'b1;
                ctrl[MAR_LOAD] = 1'b1;
            end
            T1: begin
                ctrl[RAM_OUT] = 1'b1;
                ctrl[IR_LOAD] = 1'b1;
                ctrl[PC_INC]  = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl[IR_OUT]   = 1'b1;
                        ctrl[MAR_LOAD] = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl[IR_OUT] = 1'b1;
                        ctrl[A_LOAD] = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl[IR_OUT] = 1'b1;
                        ctrl[JUMP]   = 1'b1;
                    end
                    OP_JC: begin
                        ctrl[IR_OUT] = bus.CARRY_IN;
                        ctrl[JUMP]   = bus.CARRY_IN;
                    end
                    OP_JZ: begin
                        ctrl[IR_OUT] = bus.ZERO_IN;
                        ctrl[JUMP]   = bus.ZERO_IN;
                    end
                    OP_OUT: begin
                        ctrl[A_OUT]    = 1'b1;
                        ctrl[OUT_LOAD] = 1'b1;
                    end
                    OP_HLT:  ctrl[HALT] = 1'b1;
                    default: ctrl = '0;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl[RAM_OUT] = 1'b1;
                        ctrl[A_LOAD]  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[RAM_OUT] = 1'b1;
                        ctrl[B_LOAD]  = 1'b1;
                    end
                    OP_STA: begin
                        ctrl[A_OUT]  = 1'b1;
                        ctrl[RAM_IN] = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl[ALU_OUT]    = 1'b1;
                    ctrl[A_LOAD]     = 1'b1;
                    ctrl[FLAGS_LOAD] = 1'b1;
                    ctrl[ALU_SUB]    = (opcode == OP_SUB);
                end
            end
            S_HALT:  ctrl[HALT] = 1'b1;
            default: ctrl = '0;
        endcase
    end

    assign bus.CTRL_WORD = ctrl;
    assign bus.STEP_OUT  = 3'(step);
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: instruction table plus reset/halt corner sequences.
module tb_control_sequencer;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    control_sequencer_if #(.INSTR_W(8), .CTRL_W(16)) bus ();

    control_sequencer #(.INSTR_W(8), .CTRL_W(16)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  instr;
        logic        carry;
        logic        zero;
        int          len;
        logic [0:2][15:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
        end
    endtask

    // Bus-driver exclusivity: pc_out, ram_out, ir_out, a_out, alu_out.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones(bus.CTRL_WORD & 16'h0A92) > 1) begin
                errors++;
                $display("FAIL bus_excl: ctrl=0x%04h has %0d bus drivers, expected at most 1",
                         bus.CTRL_WORD, $countones(bus.CTRL_WORD & 16'h0A92));
            end
        end
    end

    // Runs one instruction starting in T0; returns in the next T0.
    task automatic run_vec(input vec_t v);
        bus.INSTR_IN = v.instr;
        bus.CARRY_IN = v.carry;
        bus.ZERO_IN  = v.zero;
        check({v.name, " T0 step"}, 16'(bus.STEP_OUT), 16'd0);
        check({v.name, " T0 ctrl"}, bus.CTRL_WORD, 16'h000A);
        @(negedge clk);
        check({v.name, " T1 step"}, 16'(bus.STEP_OUT), 16'd1);
        check({v.name, " T1 ctrl"}, bus.CTRL_WORD, 16'h0051);
        for (int k = 0; k < v.len - 2; k++) begin
            @(negedge clk);
            check($sformatf("%s T%0d step", v.name, k + 2), 16'(bus.STEP_OUT), 16'(k + 2));
            check($sformatf("%s T%0d ctrl", v.name, k + 2), bus.CTRL_WORD, v.exp[k]);
            bus.INSTR_IN = 8'hF0;
        end
        @(negedge clk);
        check({v.name, " end step"}, 16'(bus.STEP_OUT), 16'd0);
    endtask

    initial begin
        vecs[0]  = '{"NOP",   8'h00, 1'b0, 1'b0, 3, {16'h0000, 16'h0000, 16'h0000}};
        vecs[1]  = '{"LDA",   8'h1C, 1'b0, 1'b0, 4, {16'h0088, 16'h0110, 16'h0000}};
        vecs[2]  = '{"ADD",   8'h2A, 1'b0, 1'b0, 5, {16'h0088, 16'h0410, 16'h2900}};
        vecs[3]  = '{"SUB",   8'h3A, 1'b0, 1'b0, 5, {16'h0088, 16'h0410, 16'h3900}};
        vecs[4]  = '{"STA",   8'h4E, 1'b0, 1'b0, 4, {16'h0088, 16'h0220, 16'h0000}};
        vecs[5]  = '{"LDI",   8'h57, 1'b0, 1'b0, 3, {16'h0180, 16'h0000, 16'h0000}};
        vecs[6]  = '{"JMP",   8'h65, 1'b0, 1'b0, 3, {16'h0084, 16'h0000, 16'h0000}};
        vecs[7]  = '{"JC c0", 8'h73, 1'b0, 1'b1, 3, {16'h0000, 16'h0000, 16'h0000}};
        vecs[8]  = '{"JC c1", 8'h73, 1'b1, 1'b0, 3, {16'h0084, 16'h0000, 16'h0000}};
        vecs[9]  = '{"JZ z0", 8'h83, 1'b1, 1'b0, 3, {16'h0000, 16'h0000, 16'h0000}};
        vecs[10] = '{"JZ z1", 8'h83, 1'b0, 1'b1, 3, {16'h0084, 16'h0000, 16'h0000}};
        vecs[11] = '{"OUT",   8'hE0, 1'b0, 1'b0, 3, {16'h4200, 16'h0000, 16'h0000}};
        vecs[12] = '{"UND9",  8'h9F, 1'b1, 1'b1, 3, {16'h0000, 16'h0000, 16'h0000}};
        vecs[13] = '{"UNDD",  8'hD1, 1'b1, 1'b1, 3, {16'h0000, 16'h0000, 16'h0000}};
        vecs[14] = '{"UNDB",  8'hB4, 1'b0, 1'b0, 3, {16'h0000, 16'h0000, 16'h0000}};
        vecs[15] = '{"ADD2",  8'h2F, 1'b1, 1'b1, 5, {16'h0088, 16'h0410, 16'h2900}};

        rst = 1'b0;
        bus.INSTR_IN = 8'h00;
        bus.CARRY_IN = 1'b0;
        bus.ZERO_IN  = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        check("reset step", 16'(bus.STEP_OUT), 16'd5);
        check("reset ctrl", bus.CTRL_WORD, 16'h0000);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // HLT enters S_HALT and stays there until reset.
        bus.INSTR_IN = 8'hF0;
        check("HLT T0 ctrl", bus.CTRL_WORD, 16'h000A);
        @(negedge clk);
        check("HLT T1 ctrl", bus.CTRL_WORD, 16'h0051);
        @(negedge clk);
        check("HLT T2 step", 16'(bus.STEP_OUT), 16'd2);
        check("HLT T2 ctrl", bus.CTRL_WORD, 16'h8000);
        bus.INSTR_IN = 8'h00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("halt hold %0d step", c), 16'(bus.STEP_OUT), 16'd6);
            check($sformatf("halt hold %0d ctrl", c), bus.CTRL_WORD, 16'h8000);
        end
        rst = 1'b0;
        @(negedge clk);
        check("halt reset step", 16'(bus.STEP_OUT), 16'd5);
        check("halt reset ctrl", bus.CTRL_WORD, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        check("halt release step", 16'(bus.STEP_OUT), 16'd0);

        // Reset in T3 of ADD while INSTR_IN toggles.
        bus.INSTR_IN = 8'h2A;
        @(negedge clk);
        @(negedge clk);
        check("midrst T2 ctrl", bus.CTRL_WORD, 16'h0088);
        @(negedge clk);
        check("midrst T3 step", 16'(bus.STEP_OUT), 16'd3);
        check("midrst T3 ctrl", bus.CTRL_WORD, 16'h0410);
        rst = 1'b0;
        bus.INSTR_IN = 8'h5F;
        #2 bus.INSTR_IN = 8'hA3;
        @(negedge clk);
        check("midrst step", 16'(bus.STEP_OUT), 16'd5);
        check("midrst ctrl", bus.CTRL_WORD, 16'h0000);
        bus.INSTR_IN = 8'hFF;
        @(negedge clk);
        check("midrst hold step", 16'(bus.STEP_OUT), 16'd5);
        rst = 1'b1;
        @(negedge clk);
        vecs[0].instr = 8'h00;
        run_vec(vecs[0]);
        run_vec(vecs[5]);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
